// File: rtl/pool_pkg.sv
// Shared types and width helper for the streaming 2-D pooling engine.
package pool_pkg;

   typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_FLUSH = 2'd2
   } pool_state_t;

   // Accumulator must hold the sum of WIN*WIN full-scale pixels.
   function automatic int acc_width(input int data_w, input int win);
      return data_w + 2 * $clog2(win);
   endfunction

endpackage

// File: rtl/pool_acc_buf.sv
// Per-window-column accumulator storage: one combinational read port, one write port.
module pool_acc_buf #(
   parameter int ENTRIES = 14,
   parameter int ACC_W   = 12,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [ACC_W-1:0] rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [ACC_W-1:0] wr_data
);

   logic [ACC_W-1:0] mem [ENTRIES];

   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping WIN x WIN average/max pooler, one pixel per cycle in raster order.
// Optional macro POOL_ROUND_EN: average mode rounds half up and saturates instead of truncating.
module pool2d_stream
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int WIN    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_done
);

   localparam int LW      = $clog2(WIN);
   localparam int SH      = 2 * LW;
   localparam int ACC_W   = acc_width(DATA_W, WIN);
   localparam int TW      = ACC_W + 1;
   localparam int ENTRIES = IMG_W / WIN;
   localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CW      = $clog2(IMG_W);
   localparam int RW      = $clog2(IMG_H);

`ifdef POOL_ROUND_EN
   function automatic logic [DATA_W-1:0] avg_div(input logic [ACC_W-1:0] sum);
      logic [TW-1:0] t;
      t = ({1'b0, sum} + TW'(WIN * WIN / 2)) >> SH;
      return (|t[TW-1:DATA_W]) ? {DATA_W{1'b1}} : t[DATA_W-1:0];
   endfunction
`else
   function automatic logic [DATA_W-1:0] avg_div(input logic [ACC_W-1:0] sum);
      return DATA_W'(sum >> SH);
   endfunction
`endif

   pool_state_t       state;
   pool_mode_t        mode_q;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              run_q;
   logic              vld_p1;
   logic [DATA_W-1:0] res_p1;

   logic              in_xfer, out_xfer;
   logic              first_px, last_px, frame_end, use_max;
   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  acc_rd, pix_ext, acc_nxt;
   logic [DATA_W-1:0] res_nxt;

   assign in_ready   = run_q && (state != S_FLUSH) && (!vld_p1 || out_ready);
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = vld_p1 && out_ready;
   assign frame_done = (state == S_FLUSH) && out_xfer && !clr;
   assign out_valid  = vld_p1;
   assign out_data   = res_p1;

   assign first_px  = (row[LW-1:0] == '0) && (col[LW-1:0] == '0);
   assign last_px   = (&row[LW-1:0]) && (&col[LW-1:0]);
   assign frame_end = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign idx       = IDX_W'(col >> LW);
   assign pix_ext   = ACC_W'(in_data);

   // The first pixel of a frame must obey the live mode input, later ones the latched mode.
   assign use_max = (state == S_IDLE) ? (pool_mode_t'(mode) == POOL_MAX) : (mode_q == POOL_MAX);

   pool_acc_buf #(
      .ENTRIES (ENTRIES),
      .ACC_W   (ACC_W),
      .IDX_W   (IDX_W)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (idx),
      .rd_data (acc_rd),
      .wr_en   (in_xfer && !clr),
      .wr_idx  (idx),
      .wr_data (acc_nxt)
   );

   // Stage p0: reduce incoming pixel into the column's accumulator
   always_comb begin
      acc_nxt = acc_rd + pix_ext;
      if (first_px)
         acc_nxt = pix_ext;
      else if (use_max)
         acc_nxt = (pix_ext > acc_rd) ? pix_ext : acc_rd;
   end

   assign res_nxt = use_max ? acc_nxt[DATA_W-1:0] : avg_div(acc_nxt);

   // Stage p1: counters, FSM and held output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mode_q <= POOL_AVG;
         col    <= '0;
         row    <= '0;
         run_q  <= 1'b0;
         vld_p1 <= 1'b0;
         res_p1 <= '0;
      end else begin
         run_q <= 1'b1;
         if (clr) begin
            state  <= S_IDLE;
            col    <= '0;
            row    <= '0;
            vld_p1 <= 1'b0;
         end else begin
            if (in_xfer) begin
               if (col == CW'(IMG_W - 1)) begin
                  col <= '0;
                  row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end

            if (in_xfer && last_px) begin
               vld_p1 <= 1'b1;
               res_p1 <= res_nxt;
            end else if (out_xfer) begin
               vld_p1 <= 1'b0;
            end

            case (state)
               S_IDLE: begin
                  if (in_xfer) begin
                     mode_q <= pool_mode_t'(mode);
                     state  <= S_ACC;
                  end
               end
               S_ACC: begin
                  if (in_xfer && frame_end) state <= S_FLUSH;
               end
               S_FLUSH: begin
                  if (out_xfer) begin
                     state <= S_IDLE;
                     col   <= '0;
                     row   <= '0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream on a 4x4 frame with 2x2 windows; honours POOL_ROUND_EN.
`timescale 1ns/1ps
module tb_pool2d_stream;

   localparam int DW = 8;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int WN = 2;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          clr       = 1'b0;
   logic          mode      = 1'b0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          frame_done;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fd_cnt    = 0;
   int frm [IW*IH];
   int exp_q [$];
   int lit [4];
   bit stall_req = 1'b0;

   always #5 clk = ~clk;

   pool2d_stream #(
      .DATA_W (DW),
      .IMG_W  (IW),
      .IMG_H  (IH),
      .WIN    (WN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .frame_done (frame_done)
   );

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int avg_ref(input int sum);
      int r;
`ifdef POOL_ROUND_EN
      r = (sum + WN*WN/2) / (WN*WN);
      if (r > 255) r = 255;
`else
      r = sum / (WN*WN);
`endif
      return r;
   endfunction

   // Expected pooled outputs for the first n raster pixels of frm, in emission order.
   function automatic void model(input int n, input bit mx);
      exp_q.delete();
      for (int wr = 0; wr < IH/WN; wr++) begin
         for (int wc = 0; wc < IW/WN; wc++) begin
            int last_idx, sum, mxv, v;
            last_idx = (wr*WN + WN-1)*IW + wc*WN + WN-1;
            if (last_idx < n) begin
               sum = 0;
               mxv = 0;
               for (int dy = 0; dy < WN; dy++) begin
                  for (int dx = 0; dx < WN; dx++) begin
                     v = frm[(wr*WN + dy)*IW + wc*WN + dx];
                     sum += v;
                     if (v > mxv) mxv = v;
                  end
               end
               exp_q.push_back(mx ? mxv : avg_ref(sum));
            end
         end
      end
   endfunction

   task automatic pin_model(input string name);
      chk({name, "_len"}, exp_q.size(), 4);
      if (exp_q.size() == 4)
         for (int i = 0; i < 4; i++) chk(name, exp_q[i], lit[i]);
   endtask

   task automatic push(input int p, input bit m);
      int g;
      g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = p[DW-1:0];
      mode     = m;
      #1;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 100) chk("push_timeout", g, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input int n, input bit mx, input bit tog);
      for (int i = 0; i < n; i++) push(frm[i], (tog && i[0]) ? ~mx : mx);
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk(name, exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < IW*IH; i++) frm[i] = i;
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < IW*IH; i++) frm[i] = v;
   endtask

   // Output checker: every accepted pixel against the model, held data while stalled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && !clr) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
               else chk("out_data", int'(out_data), exp_q.pop_front());
            end else if (out_valid && !out_ready) begin
               chk("hold_data", int'(out_data), (exp_q.size() != 0) ? exp_q[0] : -1);
               chk("blocked_in_ready", int'(in_ready), 0);
            end
            if (frame_done) fd_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (stall_req && out_valid) begin
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
            stall_req = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", int'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("rel_in_ready_high", int'(in_ready), 1);

      // Average, ramp
      fill_ramp();
      fd_cnt = 0;
`ifdef POOL_ROUND_EN
      lit = '{3, 5, 11, 13};
`else
      lit = '{2, 4, 10, 12};
`endif
      model(16, 1'b0);
      pin_model("model_avg");
      send(16, 1'b0, 1'b0);
      drain("avg_drain");
      chk("avg_frame_done", fd_cnt, 1);

      // Max, ramp, mode toggled mid-frame
      fd_cnt = 0;
      lit = '{5, 7, 13, 15};
      model(16, 1'b1);
      pin_model("model_max");
      send(16, 1'b1, 1'b1);
      drain("max_drain");
      chk("max_frame_done", fd_cnt, 1);

      // Full-scale average
      fill_const(255);
      fd_cnt = 0;
      lit = '{255, 255, 255, 255};
      model(16, 1'b0);
      pin_model("model_sat");
      send(16, 1'b0, 1'b0);
      drain("sat_drain");
      chk("sat_frame_done", fd_cnt, 1);

      // Downstream stall after first output
      fill_ramp();
      fd_cnt = 0;
      model(16, 1'b0);
      stall_req = 1'b1;
      send(16, 1'b0, 1'b0);
      drain("stall_drain");
      chk("stall_taken", int'(stall_req), 0);
      chk("stall_frame_done", fd_cnt, 1);

      // Asynchronous reset mid-frame
      fd_cnt = 0;
      model(7, 1'b0);
      send(7, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_queue", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      fd_cnt = 0;
      model(16, 1'b0);
      send(16, 1'b0, 1'b0);
      drain("postrst_drain");
      chk("postrst_frame_done", fd_cnt, 1);

      // Frame abort with simultaneous input transfer, then fresh constant frame
      fd_cnt = 0;
      model(7, 1'b0);
      send(7, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd7;
      clr      = 1'b1;
      #1;
      chk("clr_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr      = 1'b0;
      chk("clr_out_valid", int'(out_valid), 0);
      chk("clr_queue", exp_q.size(), 0);
      fill_const(9);
      lit = '{9, 9, 9, 9};
      model(16, 1'b0);
      pin_model("model_nine");
      send(16, 1'b0, 1'b0);
      drain("clr_drain");
      chk("clr_frame_done", fd_cnt, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
